// File: rtl/conv3x3_engine.sv
// Pipelined 3x3 signed convolution over a raster stream of unsigned pixel windows.
// Optional macro CONV3X3_ENGINE_RELU_EN clamps negative results to zero.
module conv3x3_engine #(
  parameter int IMG_Width  = 5,
  parameter int IMG_Height = 5,
  parameter int Datawidth  = 8,
  parameter int FRAC       = 4
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic [Datawidth-1:0] R00,
  input  logic [Datawidth-1:0] R01,
  input  logic [Datawidth-1:0] R02,
  input  logic [Datawidth-1:0] R10,
  input  logic [Datawidth-1:0] R11,
  input  logic [Datawidth-1:0] R12,
  input  logic [Datawidth-1:0] R20,
  input  logic [Datawidth-1:0] R21,
  input  logic [Datawidth-1:0] R22,
  input  logic                 Valid_IN,
  input  logic                 Weight_WE,
  input  logic [Datawidth-1:0] Weight_In,
  input  logic [Datawidth-1:0] Bias,
  output logic [Datawidth-1:0] Out,
  output logic                 Valid_OUT,
  output logic                 Weight_Ready,
  output logic                 Frame_Done
);

  localparam int PW    = 2*Datawidth + 1;
  localparam int ACC_W = 2*Datawidth + 5;
  localparam int CW    = (IMG_Width  > 1) ? $clog2(IMG_Width)  : 1;
  localparam int RW    = (IMG_Height > 1) ? $clog2(IMG_Height) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_Width - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_Height - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2**(Datawidth-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(2**(Datawidth-1));

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [3:0]    wr_idx;
  logic signed [Datawidth-1:0] w [9];

  logic [Datawidth-1:0] pix [9];
  logic signed [PW-1:0] pix_ext [9];
  logic signed [PW-1:0] w_ext [9];
  logic signed [ACC_W-1:0] bias_ext;
  logic interior, frame_last;

  logic signed [PW-1:0]    prod_p1 [9];
  logic                    vld_p1, last_p1;
  logic signed [ACC_W-1:0] row_p2 [3];
  logic                    vld_p2, last_p2;
  logic signed [ACC_W-1:0] sum_p3;
  logic                    vld_p3, last_p3;

  function automatic logic signed [Datawidth-1:0] sat_shift(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> FRAC;
    if (s > SAT_MAX)      return Datawidth'(SAT_MAX);
    else if (s < SAT_MIN) return Datawidth'(SAT_MIN);
    else                  return Datawidth'(s);
  endfunction

  function automatic logic signed [Datawidth-1:0] relu(input logic signed [Datawidth-1:0] v);
`ifdef CONV3X3_ENGINE_RELU_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  always_comb begin
    pix = '{R00, R01, R02, R10, R11, R12, R20, R21, R22};
    for (int i = 0; i < 9; i++) begin
      pix_ext[i] = PW'($signed({1'b0, pix[i]}));
      w_ext[i]   = PW'(w[i]);
    end
    bias_ext   = ACC_W'($signed(Bias)) <<< FRAC;
    interior   = (col >= COL_TWO) && (row >= ROW_TWO);
    frame_last = (col == COL_LAST) && (row == ROW_LAST);
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      col          <= '0;
      row          <= '0;
      wr_idx       <= '0;
      Weight_Ready <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        w[i]       <= '0;
        prod_p1[i] <= '0;
      end
      for (int r = 0; r < 3; r++) row_p2[r] <= '0;
      sum_p3    <= '0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vld_p3    <= 1'b0;
      last_p1   <= 1'b0;
      last_p2   <= 1'b0;
      last_p3   <= 1'b0;
      Out       <= '0;
      Valid_OUT <= 1'b0;
      Frame_Done <= 1'b0;
    end else begin
      if (Valid_IN) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      // Weight writes land after this edge, so the window accepted now sees the old set
      if (Weight_WE) begin
        w[wr_idx] <= $signed(Weight_In);
        wr_idx    <= (wr_idx == 4'd8) ? 4'd0 : wr_idx + 4'd1;
        if (wr_idx == 4'd0)      Weight_Ready <= 1'b0;
        else if (wr_idx == 4'd8) Weight_Ready <= 1'b1;
      end

      // stage 1: nine signed products
      vld_p1  <= Valid_IN & interior & Weight_Ready;
      last_p1 <= Valid_IN & frame_last;
      for (int i = 0; i < 9; i++) prod_p1[i] <= pix_ext[i] * w_ext[i];

      // stage 2: row sums
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
      for (int r = 0; r < 3; r++)
        row_p2[r] <= ACC_W'(prod_p1[3*r]) + ACC_W'(prod_p1[3*r+1]) + ACC_W'(prod_p1[3*r+2]);

      // stage 3: total plus scaled bias
      vld_p3  <= vld_p2;
      last_p3 <= last_p2;
      sum_p3  <= row_p2[0] + row_p2[1] + row_p2[2] + bias_ext;

      // output: shift, saturate, hold when idle
      Valid_OUT  <= vld_p3;
      Frame_Done <= last_p3;
      if (vld_p3) Out <= relu(sat_shift(sum_p3));
    end
  end

endmodule

// File: tb/tb_conv3x3_engine.sv
// Directed bench for conv3x3_engine on a 5x5 frame with hand-computed results.
module tb_conv3x3_engine;

`ifdef CONV3X3_ENGINE_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       CLR;
  logic [7:0] R00, R01, R02, R10, R11, R12, R20, R21, R22;
  logic       Valid_IN, Weight_WE;
  logic [7:0] Weight_In, Bias;
  logic [7:0] Out;
  logic       Valid_OUT, Weight_Ready, Frame_Done;

  conv3x3_engine #(.IMG_Width(5), .IMG_Height(5), .Datawidth(8), .FRAC(4)) dut (
    .CLK(CLK), .CLR(CLR),
    .R00(R00), .R01(R01), .R02(R02), .R10(R10), .R11(R11), .R12(R12),
    .R20(R20), .R21(R21), .R22(R22),
    .Valid_IN(Valid_IN), .Weight_WE(Weight_WE), .Weight_In(Weight_In), .Bias(Bias),
    .Out(Out), .Valid_OUT(Valid_OUT), .Weight_Ready(Weight_Ready), .Frame_Done(Frame_Done)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int vo_cyc[$];
  int vo_val[$];
  int fd_cyc[$];
  int acc_cyc[25];
  int pmode = 0;
  int pconst = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge CLK) begin
    cyc++;
    #1;
    if (Valid_OUT) begin
      vo_cyc.push_back(cyc);
      vo_val.push_back(int'($signed(Out)));
    end
    if (Frame_Done) fd_cyc.push_back(cyc);
  end

  function automatic int pix(input int r, input int c);
    if (r < 0 || c < 0) return 0;
    return (pmode == 1) ? (c + 10*r) : pconst;
  endfunction

  task automatic drive_pixel(input int k, input bit we = 1'b0, input int wv = 0);
    int r, c;
    r = k / 5;
    c = k % 5;
    @(negedge CLK);
    R00 = 8'(pix(r-2, c-2)); R01 = 8'(pix(r-2, c-1)); R02 = 8'(pix(r-2, c));
    R10 = 8'(pix(r-1, c-2)); R11 = 8'(pix(r-1, c-1)); R12 = 8'(pix(r-1, c));
    R20 = 8'(pix(r,   c-2)); R21 = 8'(pix(r,   c-1)); R22 = 8'(pix(r,   c));
    Valid_IN  = 1'b1;
    Weight_WE = we;
    Weight_In = 8'(wv);
    acc_cyc[k] = cyc + 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      Valid_IN  = 1'b0;
      Weight_WE = 1'b0;
    end
  endtask

  task automatic load_w(input int v, input bit ident, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      Valid_IN  = 1'b0;
      Weight_WE = 1'b1;
      Weight_In = ident ? ((i == 4) ? 8'd16 : 8'd0) : 8'(v);
    end
    idle(1);
  endtask

  task automatic clear_logs();
    vo_cyc.delete();
    vo_val.delete();
    fd_cyc.delete();
  endtask

  // expv == -999 selects the raster identity result R11 = (c-1) + 10*(r-1)
  task automatic check_frame(input string tag, input int nexp, input int expv);
    int k, r, c, e;
    check_val({tag, "_nvalid"}, vo_cyc.size(), nexp);
    for (int j = 0; j < vo_cyc.size() && j < nexp; j++) begin
      r = 2 + j / 3;
      c = 2 + j % 3;
      k = r*5 + c;
      e = (expv == -999) ? ((c-1) + 10*(r-1)) : expv;
      check_val($sformatf("%s_out%0d", tag, j), vo_val[j], e);
      check_val($sformatf("%s_lat%0d", tag, j), vo_cyc[j] - acc_cyc[k], 3);
    end
    check_val({tag, "_ndone"}, fd_cyc.size(), 1);
    if (fd_cyc.size() > 0) check_val({tag, "_done_lat"}, fd_cyc[0] - acc_cyc[24], 3);
  endtask

  task automatic run_frame(input string tag, input int nexp, input int expv);
    clear_logs();
    for (int k = 0; k < 25; k++) drive_pixel(k);
    idle(6);
    check_frame(tag, nexp, expv);
  endtask

  task automatic do_clr();
    @(negedge CLK);
    CLR = 1'b1; Valid_IN = 1'b1; Weight_WE = 1'b1; Weight_In = 8'h55;
    @(negedge CLK);
    CLR = 1'b0; Valid_IN = 1'b0; Weight_WE = 1'b0;
  endtask

  initial begin
    CLR = 1'b1; Valid_IN = 1'b0; Weight_WE = 1'b0; Weight_In = '0; Bias = '0;
    {R00, R01, R02, R10, R11, R12, R20, R21, R22} = '0;
    repeat (2) @(negedge CLK);
    CLR = 1'b0;
    check_val("rst_out", int'(Out), 0);
    check_val("rst_vout", int'(Valid_OUT), 0);
    check_val("rst_ready", int'(Weight_Ready), 0);
    check_val("rst_done", int'(Frame_Done), 0);

    load_w(16, 1'b0, 8);
    check_val("ready_8of9", int'(Weight_Ready), 0);
    load_w(16, 1'b0, 1);
    check_val("ready_9of9", int'(Weight_Ready), 1);
    pmode = 0; pconst = 10;
    run_frame("avg90", 9, 90);

    Bias = 8'd5;
    run_frame("bias5", 9, 95);
    Bias = 8'd0;

    load_w(1, 1'b0, 9);
    run_frame("floor_pos", 9, 5);
    load_w(-1, 1'b0, 9);
    run_frame("floor_neg", 9, RELU ? 0 : -6);

    pconst = 255;
    load_w(127, 1'b0, 9);
    run_frame("sat_hi", 9, 127);
    load_w(-128, 1'b0, 9);
    run_frame("sat_lo", 9, RELU ? 0 : -128);

    pconst = 10;
    load_w(-16, 1'b0, 9);
    run_frame("neg90", 9, RELU ? 0 : -90);

    pmode = 1;
    load_w(0, 1'b1, 9);
    run_frame("raster", 9, -999);

    // identity weights, pixels 10; W00 rewritten to 16 alongside window (2,2)
    pmode = 0; pconst = 10;
    clear_logs();
    for (int k = 0; k < 25; k++) drive_pixel(k, k == 12, 16);
    idle(6);
    check_frame("same_cycle", 1, 10);
    check_val("same_cycle_ready", int'(Weight_Ready), 0);

    // index is now 1; fill 1..8 so every weight is 16, then clear mid-frame
    load_w(16, 1'b0, 8);
    check_val("refill_ready", int'(Weight_Ready), 1);
    clear_logs();
    for (int k = 0; k < 13; k++) drive_pixel(k);
    do_clr();
    check_val("clr_out", int'(Out), 0);
    check_val("clr_vout", int'(Valid_OUT), 0);
    check_val("clr_ready", int'(Weight_Ready), 0);
    check_val("clr_done", int'(Frame_Done), 0);
    idle(5);
    check_val("clr_inflight", vo_cyc.size(), 0);

    load_w(16, 1'b0, 8);
    check_val("partial_ready", int'(Weight_Ready), 0);
    run_frame("partial", 0, 0);
    load_w(16, 1'b0, 1);
    check_val("reload_ready", int'(Weight_Ready), 1);
    run_frame("after_clr", 9, 90);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv3x3_engine.md
CONV3X3_ENGINE -- requirements
Module: conv3x3_engine

Interface
REQ-001 SHALL have parameter IMG_Width, default 5, meaning image columns.
REQ-002 SHALL have parameter IMG_Height, default 5, meaning image rows.
REQ-003 SHALL have parameter Datawidth, default 8, meaning pixel, weight, bias and output width.
REQ-004 SHALL have parameter FRAC, default 4, meaning weight fractional bits (output right shift).
REQ-005 SHALL have one clock and a synchronous, active-high reset: CLK  input  1  rising-edge clock.
REQ-006 SHALL have CLR  input  1  synchronous active-high clear.
REQ-007 SHALL have R00,R01,R02,R10,R11,R12,R20,R21,R22  input  Datawidth each  unsigned 3x3 window, row-major; R22 is the newest pixel.
REQ-008 SHALL have Valid_IN  input  1  one-cycle strobe: a new window is on R00..R22.
REQ-009 SHALL have Weight_WE  input  1  serial weight write strobe.
REQ-010 SHALL have Weight_In  input  Datawidth  signed coefficient.
REQ-011 SHALL have Bias  input  Datawidth  signed bias, static during a frame.
REQ-012 SHALL have Out  output  Datawidth  signed result.
REQ-013 SHALL have Valid_OUT  output  1  Out qualifier.
REQ-014 SHALL have Weight_Ready  output  1  full coefficient set loaded.
REQ-015 SHALL have Frame_Done  output  1  one-cycle pulse with the last output of a frame.

Function
REQ-016 SHALL keep column counter col (0..IMG_Width-1) and row counter row (0..IMG_Height-1) for the R22 position; both advance only on Valid_IN, col wraps and increments row, and row wraps to 0 after the last pixel.
REQ-017 SHALL mark a window interior when col>=2 and row>=2; non-interior windows never raise Valid_OUT.
REQ-018 SHALL store weights W00..W22 via a 4-bit index: each Weight_WE writes Weight_In to W[index], index 0..8 then wraps to 0.
REQ-019 SHALL clear Weight_Ready on an index-0 write and set it on the index-8 write.
REQ-020 SHALL compute the window result using weights as registered at the Valid_IN cycle; a simultaneous Weight_WE takes effect from the next window.
REQ-021 SHALL suppress Valid_OUT for windows accepted while Weight_Ready=0; counters still advance.
REQ-022 SHALL compute 9 signed products (pixel zero-extended by 1 bit) in stage 1, 3 row sums in stage 2, and in stage 3 the total plus sign-extended Bias<<FRAC; accumulator width 2*Datawidth+5, no overflow.
REQ-023 SHALL arithmetic-shift the stage-3 sum right by FRAC (floor) and saturate to [-2^(Datawidth-1), 2^(Datawidth-1)-1].
REQ-024 SHALL present Out and Valid_OUT exactly 3 cycles after the accepting Valid_IN edge; fully pipelined, one window per cycle.
REQ-025 SHALL hold Out at its last value when Valid_OUT=0.
REQ-026 SHALL pulse Frame_Done with Valid_OUT for window (IMG_Height-1, IMG_Width-1), even if Valid_OUT is suppressed per REQ-021.

Reset
REQ-027 SHALL on CLR=1 at a rising edge set col, row, index, all W, all pipeline registers, Out, Valid_OUT, Weight_Ready and Frame_Done to 0.
REQ-028 SHALL discard in-flight windows on CLR mid-frame; the next Valid_IN is pixel (0,0).
REQ-029 SHALL give CLR priority over simultaneous Valid_IN and Weight_WE.

Configuration
REQ-030 SHALL, when macro CONV3X3_ENGINE_RELU_EN is defined, replace negative saturated results with 0 before Out.
REQ-031 SHALL, when CONV3X3_ENGINE_RELU_EN is undefined, output the signed saturated result unchanged.

Verification
REQ-032 SHALL cover: 9 weights 16, Bias 0, 5x5 frame all pixels 10 -> exactly 9 Valid_OUT, each Out=90, Frame_Done with 9th, each 3 cycles after its Valid_IN.
REQ-033 SHALL cover: weights 127, pixels 255 -> Out=127 (saturated); weights -128, pixels 255, RELU off -> Out=-128.
REQ-034 SHALL cover: weights -16, pixels 10, Bias 0 -> Out=0 with RELU_EN, Out=-90 (0xA6) without.
REQ-035 SHALL cover: raster 5x5 with pixel=col+10*row, identity weight (W11=16 only) -> Valid_OUT only at cols 2..4 rows 2..4, Out=R11 value (e.g. 11 for window at row 2, col 2).
REQ-036 SHALL cover: only 8 weights loaded -> no Valid_OUT for a full frame, Frame_Done still pulses; Weight_WE and Valid_IN same cycle -> that window uses old weight.
REQ-037 SHALL cover: CLR after 12 pixels -> all outputs 0 next cycle, Weight_Ready=0; reload weights, next frame's first Valid_OUT at its 13th pixel.
